chroma_job_sequencer: RTL and testbench

Command sequencer for the YUV444→RGB conversion path. It accepts one conversion job at a time as a source address, destination address and byte length, and splits it into fixed-size chunks. For each chunk it programs the memory-to-stream read mover and the stream-to-memory write mover, then counts converted output beats to detect chunk completion. It sits between a register/CPU front end and the two movers that surround the `yuv444toRGB` core.

---
 rtl/chroma_job_sequencer.sv | 167 ++++++++++++++++
 tb/tb_chroma_job_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chroma_job_sequencer.sv
// Job sequencer for the YUV444->RGB path: splits a job into chunks and drives the two movers.
// Optional interrupt output enabled by defining CHROMA_SEQ_IRQ_EN.
module chroma_job_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned LEN_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned CHUNK_BYTES = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [ADDR_WIDTH-1:0] job_src,
  input  logic [ADDR_WIDTH-1:0] job_dst,
  input  logic [LEN_WIDTH-1:0]  job_len,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] rd_src,
  output logic [LEN_WIDTH-1:0]  rd_len,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_dest,
  input  logic                  out_beat,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  irq,
  input  logic                  irq_clr
);

  localparam int unsigned BB     = DATA_WIDTH / 8;
  localparam int unsigned BB_LOG = $clog2(BB);
  localparam int unsigned CW     = $clog2(CHUNK_BYTES / BB) + 1;
  localparam logic [LEN_WIDTH-1:0] ChunkLen = LEN_WIDTH'(CHUNK_BYTES);
  localparam logic [LEN_WIDTH-1:0] BeatMask = LEN_WIDTH'(BB - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d, cl;
  logic                  rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc, target;
  logic                  bad_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Command fields come straight from registers, so they stay put while a valid is pending.
  assign cl      = (rem_q > ChunkLen) ? ChunkLen : rem_q;
  assign target  = CW'(cl >> BB_LOG);
  assign cnt_inc = cnt_q + CW'(out_beat);
  assign bad_len = |(job_len & BeatMask);
  assign rd_src  = src_q;
  assign rd_len  = cl;
  assign wr_dest = dst_q;
  assign err     = err_q;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    rd_pend_d = rd_pend_q;
    wr_pend_d = wr_pend_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    job_ready = 1'b0;
    rd_valid  = 1'b0;
    wr_valid  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        job_ready = 1'b1;
        if (job_valid) begin
          src_d = job_src;
          dst_d = job_dst;
          rem_d = job_len;
          err_d = bad_len;
          if (bad_len || job_len == '0) begin
            state_d = StDone;
          end else begin
            state_d   = StIssue;
            rd_pend_d = 1'b1;
            wr_pend_d = 1'b1;
            cnt_d     = '0;
          end
        end
      end
      StIssue: begin
        busy     = 1'b1;
        rd_valid = rd_pend_q;
        wr_valid = wr_pend_q;
        cnt_d    = cnt_inc;
        if (rd_ready) rd_pend_d = 1'b0;
        if (wr_ready) wr_pend_d = 1'b0;
        if ((!rd_pend_q || rd_ready) && (!wr_pend_q || wr_ready)) state_d = StWait;
      end
      StWait: begin
        busy  = 1'b1;
        cnt_d = cnt_inc;
        // The beat arriving this cycle already counts toward completion.
        if (cnt_inc >= target) begin
          src_d = src_q + ADDR_WIDTH'(cl);
          dst_d = dst_q + ADDR_WIDTH'(cl);
          rem_d = rem_q - cl;
          if (rem_q != cl) begin
            state_d   = StIssue;
            rd_pend_d = 1'b1;
            wr_pend_d = 1'b1;
            cnt_d     = '0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef CHROMA_SEQ_IRQ_EN
  logic irq_q;

  // A clear coinciding with completion loses to the set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (state_q == StDone) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q | (state_q == StDone);
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_chroma_job_sequencer.sv
// Self-checking bench for chroma_job_sequencer: directed table, corner sequences and a random
// mover/beat environment checked against a chunk-list reference model.
module tb_chroma_job_sequencer;

  localparam int unsigned AW = 64, LW = 32, DW = 64, CB = 128;
  localparam int unsigned BB = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid, job_ready;
  logic [AW-1:0] job_src, job_dst;
  logic [LW-1:0] job_len;
  logic          rd_valid, rd_ready, wr_valid, wr_ready;
  logic [AW-1:0] rd_src, wr_dest;
  logic [LW-1:0] rd_len;
  logic          out_beat, busy, done, err, irq, irq_clr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chroma_job_sequencer #(
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .DATA_WIDTH (DW),
    .CHUNK_BYTES(CB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_src  (job_src),
    .job_dst  (job_dst),
    .job_len  (job_len),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_src   (rd_src),
    .rd_len   (rd_len),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_dest  (wr_dest),
    .out_beat (out_beat),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .irq      (irq),
    .irq_clr  (irq_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_job_ready"}, job_ready, 1);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_wr_valid"}, wr_valid, 0);
    check({tag, "_rd_src"}, rd_src, 0);
    check({tag, "_rd_len"}, rd_len, 0);
    check({tag, "_wr_dest"}, wr_dest, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_irq"}, irq, 0);
  endtask

  // Runs one job; expected commands come from splitting the job into chunks arithmetically.
  task automatic run_job(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] len,
                         input bit rnd, output int ncmd);
    logic [63:0] e_src[$];
    logic [31:0] e_len[$];
    logic [63:0] e_dst[$];
    logic [63:0] a, d, h_src, h_dst;
    logic [31:0] rem, cl, h_len;
    bit          bad, rd_hold, wr_hold, seen_done;
    int          total, avail, delivered, last_beat, waitc;
    ncmd = 0;
    bad  = (len % BB) != 0;
    a    = src;
    d    = dst;
    rem  = bad ? 32'd0 : len;
    while (rem != 0) begin
      cl = (rem < CB) ? rem : CB;
      e_src.push_back(a);
      e_len.push_back(cl);
      e_dst.push_back(d);
      a   = a + 64'(cl);
      d   = d + 64'(cl);
      rem = rem - cl;
    end
    total = bad ? 0 : int'(len / BB);
    @(negedge clk);
    waitc = 0;
    while (!job_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("job_ready_wait", job_ready, 1);
    if (!job_ready) return;
    job_valid = 1'b1;
    job_src   = src;
    job_dst   = dst;
    job_len   = len;
    avail = 0; delivered = 0; last_beat = 0;
    rd_hold = 0; wr_hold = 0; seen_done = 0;
    h_src = '0; h_dst = '0; h_len = '0;
    for (int cyc = 1; cyc <= 4000 && !seen_done; cyc++) begin
      @(negedge clk);
      job_valid = 1'b0;
      check("busy", busy, (total > 0) && !done);
      check("err", err, bad);
      if (rd_hold) begin
        check("rd_valid_hold", rd_valid, 1);
        check("rd_src_stable", rd_src, h_src);
        check("rd_len_stable", rd_len, h_len);
      end
      if (wr_hold) begin
        check("wr_valid_hold", wr_valid, 1);
        check("wr_dest_stable", wr_dest, h_dst);
      end
      if (done) begin
        seen_done = 1;
        check("done_cycle", cyc, (total > 0) ? last_beat + 1 : 1);
        check("beats_delivered", delivered, total);
        check("cmds_left", e_len.size() + e_dst.size(), 0);
      end
      out_beat = 1'b0;
      if (avail > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
        out_beat = 1'b1;
        avail--;
        delivered++;
        last_beat = cyc;
      end
      rd_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      wr_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rd_valid && rd_ready) begin
        check("rd_cmd_expected", e_len.size() > 0, 1);
        if (e_len.size() > 0) begin
          check("rd_src", rd_src, e_src[0]);
          check("rd_len", rd_len, e_len[0]);
          avail += int'(e_len[0] / BB);
          void'(e_src.pop_front());
          void'(e_len.pop_front());
          ncmd++;
        end
      end
      if (wr_valid && wr_ready) begin
        check("wr_cmd_expected", e_dst.size() > 0, 1);
        if (e_dst.size() > 0) begin
          check("wr_dest", wr_dest, e_dst[0]);
          void'(e_dst.pop_front());
        end
      end
      rd_hold = rd_valid && !rd_ready;
      wr_hold = wr_valid && !wr_ready;
      h_src = rd_src;
      h_len = rd_len;
      h_dst = wr_dest;
    end
    check("done_seen", seen_done, 1);
    out_beat = 1'b0;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("job_ready_after_done", job_ready, 1);
  endtask

  typedef struct {
    logic [63:0] src;
    logic [63:0] dst;
    logic [31:0] len;
    int          exp_ncmd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];
  int   ncmd;

  initial begin
    vecs[0] = '{src: 64'h0, dst: 64'h8, len: 32'd128, exp_ncmd: 1, exp_err: 1'b0};
    vecs[1] = '{src: 64'h0, dst: 64'h1000, len: 32'd320, exp_ncmd: 3, exp_err: 1'b0};
    vecs[2] = '{src: 64'h0, dst: 64'h0, len: 32'd12, exp_ncmd: 0, exp_err: 1'b1};
    vecs[3] = '{src: 64'h0, dst: 64'h0, len: 32'd0, exp_ncmd: 0, exp_err: 1'b0};
    vecs[4] = '{src: 64'hFFFF_FFFF_FFFF_FFC0, dst: 64'h10, len: 32'd256, exp_ncmd: 2,
                exp_err: 1'b0};
    vecs[5] = '{src: 64'd100, dst: 64'd200, len: 32'd8, exp_ncmd: 1, exp_err: 1'b0};

    rst = 1'b1;
    job_valid = 1'b0; job_src = '0; job_dst = '0; job_len = '0;
    rd_ready = 1'b0; wr_ready = 1'b0; out_beat = 1'b0; irq_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i].src, vecs[i].dst, vecs[i].len, 1'b0, ncmd);
      check("tbl_ncmd", ncmd, vecs[i].exp_ncmd);
      check("tbl_err", err, vecs[i].exp_err);
    end

    // Write mover stalls five cycles; beats arriving in the meantime must still count.
    check("stall_job_ready", job_ready, 1);
    job_valid = 1'b1; job_src = 64'h1000; job_dst = 64'h2000; job_len = 32'd128;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      job_valid = 1'b0;
      if (c == 1) begin
        check("stall_rd_valid", rd_valid, 1);
        check("stall_rd_src", rd_src, 64'h1000);
        check("stall_rd_len", rd_len, 128);
      end
      if (c >= 2 && c <= 6) check("stall_rd_valid_dropped", rd_valid, 0);
      if (c <= 6) begin
        check("stall_wr_valid_held", wr_valid, 1);
        check("stall_wr_dest_held", wr_dest, 64'h2000);
      end
      if (c == 7) check("stall_wr_valid_accepted", wr_valid, 0);
      if (c == 19) check("stall_job_ready_back", job_ready, 1);
      check("stall_done_timing", done, c == 18);
      rd_ready = (c == 1);
      wr_ready = (c == 6);
      out_beat = (c >= 2 && c <= 17);
    end

    // Interrupt: set wins over a coincident clear, then a later clear drops it.
    @(negedge clk);
    job_valid = 1'b1; job_len = 32'd0;
    @(negedge clk);
    job_valid = 1'b0;
    check("irq_done_pulse", done, 1);
`ifdef CHROMA_SEQ_IRQ_EN
    check("irq_with_done", irq, 1);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("irq_set_wins", irq, 1);
    @(negedge clk);
    check("irq_holds", irq, 1);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("irq_cleared", irq, 0);
`else
    check("irq_tied_low", irq, 0);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("irq_stays_low", irq, 0);
`endif

    // Asynchronous reset in the middle of a 16-beat job.
    @(negedge clk);
    job_valid = 1'b1; job_src = 64'h40; job_dst = 64'h80; job_len = 32'd128;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      job_valid = 1'b0;
      rd_ready = 1'b1;
      wr_ready = 1'b1;
      out_beat = (c >= 2 && c <= 6);
    end
    check("midreset_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    run_job(64'h0, 64'h8, 32'd128, 1'b0, ncmd);
    check("midreset_new_job_cmds", ncmd, 1);

    for (int j = 0; j < 30; j++) begin
      logic [63:0] s, d;
      logic [31:0] l;
      s = {$urandom(), $urandom()};
      d = {$urandom(), $urandom()};
      l = 32'($urandom_range(0, 80)) * BB;
      if ($urandom_range(0, 7) == 0) l = l + 32'($urandom_range(1, BB - 1));
      run_job(s, d, l, 1'b1, ncmd);
      check("rand_ncmd", ncmd, ((l % BB) != 0) ? 0 : (l + CB - 1) / CB);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
